next_pc_unit: RTL and testbench
===============================

Name: next_pc_unit

Overview:
- Program-counter stage of the pipelined CPU, directly downstream of the EX-stage branch/jump detector.
- Consumes the 2-bit next-type code and holds the architectural fetch PC.
- Arbitrates between sequential fetch, ID-stage predicted-taken redirect, EX-stage mispredict recovery and jump redirect.
- Generates pipeline flush pulses and keeps saturating branch/mispredict statistics.

Parameters:
- ADDR_W, 32, width of PC and all target buses
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of each statistics counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- next_type  input  2  EX-stage resolution: 00 sequential, 01 mispredict recover, 10 jump, 11 reserved (treated as 00)
- ex_is_branch  input  1  EX stage holds a valid branch this cycle
- recover_pc  input  ADDR_W  ID/EX PC+4, used when next_type=01
- jump_target  input  ADDR_W  EX jump target, used when next_type=10
- id_pred_taken  input  1  ID stage decoded a branch and predicts taken
- id_pred_target  input  ADDR_W  ID-computed branch target
- stall  input  1  load-use hazard; hold PC
- pc  output  ADDR_W  current fetch address
- fetch_valid  output  1  pc is a valid, non-squashed fetch
- flush_ifid  output  1  squash IF/ID register this cycle
- flush_idex  output  1  squash ID/EX register this cycle
- branch_cnt  output  CNT_W  resolved branches since reset
- mispred_cnt  output  CNT_W  mispredicts since reset

Behaviour:
- Reset (async, any time, including mid-redirect): pc=RESET_PC, fetch_valid=0, flush_ifid=0, flush_idex=0, counters=0, FSM=BOOT.
- FSM states:
  - BOOT: one cycle after reset deassert; pc held, fetch_valid=0; then RUN.
  - RUN: normal operation; fetch_valid=1.
  - BUBBLE: one cycle after any redirect; fetch_valid=0; then RUN. A new redirect while in BUBBLE is still honoured and re-enters BUBBLE.
- Next-PC priority, registered at posedge (one cycle latency):
  1. next_type=01 -> pc<=recover_pc
  2. next_type=10 -> pc<=jump_target
  3. id_pred_taken=1 -> pc<=id_pred_target
  4. stall=1 -> pc held
  5. otherwise pc<=pc+4
- Precedence rules:
  - EX redirects (1, 2) override stall and id_pred_taken in the same cycle.
  - id_pred_taken is ignored when an EX redirect is present (the younger instruction is squashed).
  - id_pred_taken overrides stall.
- Flush outputs are combinational, same cycle as the redirect:
  - next_type=01 or 10: flush_ifid=1 and flush_idex=1.
  - id_pred_taken honoured: flush_ifid=1, flush_idex=0.
  - Otherwise both 0.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W with no exception. Targets are loaded as-is; bits [1:0] are not checked.
- Any redirect (priorities 1-3) sends the FSM to BUBBLE.
- Counters, at posedge:
  - branch_cnt increments when ex_is_branch=1.
  - mispred_cnt increments when ex_is_branch=1 and next_type=01.
  - Both saturate at all-ones; no wrap.
- next_type=01 with ex_is_branch=0 is still a redirect, but does not update the counters.

Test Plan:
- Reset then run: assert rst mid-cycle, release -> pc=0 and fetch_valid=0 for one cycle, then pc = 0, 4, 8, 0xC on successive cycles with fetch_valid=1.
- Stall: pc=0x10, stall=1 for 3 cycles -> pc stays 0x10, flush_* = 0; release -> pc=0x14.
- Predict-then-mispredict:
  - id_pred_taken=1, id_pred_target=0x100 at pc=0x20 -> flush_ifid=1 that cycle, pc=0x100 next cycle, fetch_valid=0 one cycle.
  - Two cycles later, next_type=01, recover_pc=0x1C, ex_is_branch=1 -> both flushes=1, pc=0x1C, branch_cnt=1, mispred_cnt=1.
- Simultaneous events: next_type=10, jump_target=0x400, with id_pred_taken=1 and stall=1 in the same cycle -> pc=0x400, flush_ifid=flush_idex=1, id target ignored.
- Wrap and saturation:
  - pc=0xFFFF_FFFC, no redirect -> pc=0x0.
  - With CNT_W=4, drive 17 mispredicting branches -> both counters hold at 0xF.
- Reset mid-BUBBLE: redirect, then assert rst the following cycle -> outputs immediately return to reset values; FSM restarts in BOOT.

Source files
------------

// File: rtl/next_pc_unit.sv
// next_pc_unit: program-counter stage of the pipelined CPU.
// Holds the architectural fetch PC and chooses its next value.
// The candidates are, in priority order: EX mispredict recovery, EX jump,
// ID predicted-taken redirect, stall hold, and sequential PC+4.
// Also drives the pipeline flush pulses and the saturating branch and
// mispredict statistics.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   next_type       EX resolution: 00 seq, 01 recover, 10 jump, 11 as 00
//   ex_is_branch    EX holds a valid branch this cycle (statistics)
//   recover_pc      redirect target for next_type=01
//   jump_target     redirect target for next_type=10
//   id_pred_taken   ID predicts a taken branch to id_pred_target
//   id_pred_target  ID-computed branch target
//   stall           load-use hazard, hold PC
//   pc              current fetch address (registered)
//   fetch_valid     pc is a valid, non-squashed fetch (registered)
//   flush_ifid      squash IF/ID this cycle (combinational)
//   flush_idex      squash ID/EX this cycle (combinational)
//   branch_cnt      resolved branches since reset, saturating
//   mispred_cnt     mispredicts since reset, saturating
module next_pc_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000),
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        next_type,
  input  logic              ex_is_branch,
  input  logic [ADDR_W-1:0] recover_pc,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              id_pred_taken,
  input  logic [ADDR_W-1:0] id_pred_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    NT_SEQ     = 2'b00,
    NT_RECOVER = 2'b01,
    NT_JUMP    = 2'b10,
    NT_RSVD    = 2'b11
  } next_type_e;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_BUBBLE = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  // EX-stage resolution decode; the reserved code behaves as sequential
  logic ex_recover_c;
  logic ex_jump_c;
  assign ex_recover_c = (next_type == NT_RECOVER);
  assign ex_jump_c    = (next_type == NT_JUMP);

  // State, PC and fetch-valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Next-state, next-PC and flush selection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;

    unique case (state_q)
      // First cycle out of reset: PC held, no redirect is accepted yet
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      // A redirect is honoured in BUBBLE as well and re-enters BUBBLE
      ST_RUN, ST_BUBBLE: begin
        state_d = ST_RUN;
        if (ex_recover_c) begin
          pc_d       = recover_pc;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_d    = ST_BUBBLE;
        end else if (ex_jump_c) begin
          pc_d       = jump_target;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_d    = ST_BUBBLE;
        end else if (id_pred_taken) begin
          // Only the instruction fetched behind the predicted branch dies
          pc_d       = id_pred_target;
          flush_ifid = 1'b1;
          state_d    = ST_BUBBLE;
        end else if (stall) begin
          pc_d = pc_q;
        end else begin
          // Sequential fetch wraps silently at the top of the address space
          pc_d = pc_q + ADDR_W'(PC_STEP);
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    fetch_valid_d = (state_d == ST_RUN);
  end

  // Statistics counters, saturating at all-ones
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ex_is_branch && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (ex_is_branch && ex_recover_c && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: each directed step pushes the outputs
// expected in that cycle; a negedge monitor pops and compares.
module tb_next_pc_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic [1:0]        next_type;
  logic              ex_is_branch;
  logic [ADDR_W-1:0] recover_pc;
  logic [ADDR_W-1:0] jump_target;
  logic              id_pred_taken;
  logic [ADDR_W-1:0] id_pred_target;
  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic              fetch_valid;
  logic              flush_ifid;
  logic              flush_idex;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  next_pc_unit #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0000_0000),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .next_type     (next_type),
    .ex_is_branch  (ex_is_branch),
    .recover_pc    (recover_pc),
    .jump_target   (jump_target),
    .id_pred_taken (id_pred_taken),
    .id_pred_target(id_pred_target),
    .stall         (stall),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  typedef struct {
    int               id;
    logic [31:0]      pc;
    logic             fv;
    logic             fi;
    logic             fx;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] mc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL step %0d %s: got %h want %h", id, nm, got, want);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("pc",          e.id, pc,                 e.pc);
      chk("fetch_valid", e.id, 32'(fetch_valid),   32'(e.fv));
      chk("flush_ifid",  e.id, 32'(flush_ifid),    32'(e.fi));
      chk("flush_idex",  e.id, 32'(flush_idex),    32'(e.fx));
      chk("branch_cnt",  e.id, 32'(branch_cnt),    32'(e.bc));
      chk("mispred_cnt", e.id, 32'(mispred_cnt),   32'(e.mc));
    end
  end

  task automatic drv(input logic [1:0] nt, input logic br, input logic [31:0] rpc,
                     input logic [31:0] jt, input logic pt, input logic [31:0] ptg,
                     input logic st);
    next_type      = nt;
    ex_is_branch   = br;
    recover_pc     = rpc;
    jump_target    = jt;
    id_pred_taken  = pt;
    id_pred_target = ptg;
    stall          = st;
  endtask

  task automatic idle();
    drv(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Push outputs expected this cycle, then move to just after the next posedge
  task automatic expect_step(input logic [31:0] epc, input logic efv, input logic efi,
                             input logic efx, input logic [CNT_W-1:0] ebc,
                             input logic [CNT_W-1:0] emc);
    exp_t e;
    step_id++;
    e.id = step_id; e.pc = epc; e.fv = efv; e.fi = efi; e.fx = efx;
    e.bc = ebc; e.mc = emc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // Held in reset with a jump and prediction present: no flush may escape
    drv(2'b10, 1'b1, 32'h0, 32'h40, 1'b1, 32'h80, 1'b0);
    expect_step(32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Release mid-cycle: BOOT then sequential run
    rst = 1'b0;
    idle(); expect_step(32'h0,  1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(); expect_step(32'h0,  1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(); expect_step(32'h4,  1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(); expect_step(32'h8,  1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(); expect_step(32'hC,  1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

    // Stall holds PC for three cycles
    for (int i = 0; i < 3; i++) begin
      drv(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
      expect_step(32'h10, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    end
    idle(); expect_step(32'h10, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(); expect_step(32'h14, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(); expect_step(32'h18, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(); expect_step(32'h1C, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

    // Predict taken at 0x20, then EX mispredict two cycles later
    drv(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 1'b0);
    expect_step(32'h20, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    idle(); expect_step(32'h100, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    drv(2'b01, 1'b1, 32'h1C, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_step(32'h104, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    idle(); expect_step(32'h1C, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);

    // Jump together with prediction and stall: jump wins
    drv(2'b10, 1'b0, 32'h0, 32'h400, 1'b1, 32'h200, 1'b1);
    expect_step(32'h20, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1);
    // Prediction during BUBBLE is honoured and re-enters BUBBLE
    drv(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'h300, 1'b0);
    expect_step(32'h400, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1);
    idle(); expect_step(32'h300, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);
    // Reserved code behaves as sequential
    drv(2'b11, 1'b0, 32'h900, 32'h900, 1'b0, 32'h0, 1'b0);
    expect_step(32'h304, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
    // Recover without a branch: redirect, counters untouched
    drv(2'b01, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_step(32'h308, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1);
    // Correctly predicted branch: only branch_cnt moves
    drv(2'b00, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_step(32'h50, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);

    // Jump to the top of memory, then wrap
    drv(2'b10, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    expect_step(32'h54, 1'b1, 1'b1, 1'b1, 4'd2, 4'd1);
    idle(); expect_step(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1);
    idle(); expect_step(32'h0,         1'b1, 1'b0, 1'b0, 4'd2, 4'd1);

    // 17 mispredicting branches saturate both 4-bit counters
    for (int i = 0; i < 17; i++) begin
      int bc_e;
      int mc_e;
      bc_e = (2 + i > 15) ? 15 : 2 + i;
      mc_e = (1 + i > 15) ? 15 : 1 + i;
      drv(2'b01, 1'b1, 32'h80, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_step((i == 0) ? 32'h4 : 32'h80, (i == 0), 1'b1, 1'b1,
                  CNT_W'(bc_e), CNT_W'(mc_e));
    end
    idle(); expect_step(32'h80, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF);
    idle(); expect_step(32'h84, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);

    // Redirect, then reset asynchronously during the BUBBLE cycle
    drv(2'b10, 1'b0, 32'h0, 32'h500, 1'b0, 32'h0, 1'b0);
    expect_step(32'h88, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
    rst = 1'b1;
    drv(2'b10, 1'b1, 32'h0, 32'h600, 1'b1, 32'h700, 1'b0);
    expect_step(32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    rst = 1'b0;
    idle(); expect_step(32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(); expect_step(32'h0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(); expect_step(32'h4, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

    // Every pushed expectation must have been consumed by the monitor
    for (int k = 0; k < 5 && sb_q.size() != 0; k++) @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
